// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Optional statistics build is selected with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_HOLD = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc16 = 16'hFFFF;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating grant/conflict counters, present only when DMEM_ARB_STATS_EN is defined.
`ifdef DMEM_ARB_STATS_EN
module dmem_arb_stats
    import dmem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stat_clr,
    input  logic        a_gnt,
    input  logic        b_gnt,
    input  logic        conflict,
    output logic [15:0] stat_a_gnt,
    output logic [15:0] stat_b_gnt,
    output logic [15:0] stat_conflict
);

    logic [15:0] a_cnt_r;
    logic [15:0] b_cnt_r;
    logic [15:0] conflict_cnt_r;

    // Counters: clear wins over increment, increments stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_cnt_r        <= 16'd0;
            b_cnt_r        <= 16'd0;
            conflict_cnt_r <= 16'd0;
        end else if (stat_clr) begin
            a_cnt_r        <= 16'd0;
            b_cnt_r        <= 16'd0;
            conflict_cnt_r <= 16'd0;
        end else begin
            if (a_gnt) begin
                a_cnt_r <= sat_inc16(a_cnt_r);
            end else begin
                a_cnt_r <= a_cnt_r;
            end
            if (b_gnt) begin
                b_cnt_r <= sat_inc16(b_cnt_r);
            end else begin
                b_cnt_r <= b_cnt_r;
            end
            if (conflict) begin
                conflict_cnt_r <= sat_inc16(conflict_cnt_r);
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign stat_a_gnt    = a_cnt_r;
    assign stat_b_gnt    = b_cnt_r;
    assign stat_conflict = conflict_cnt_r;

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with burst lock and starvation bound in front of the data memory.
// Define DMEM_ARB_STATS_EN to add the statistics counters and their ports.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
`ifdef DMEM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_a_gnt,
    output logic [15:0]       stat_b_gnt,
    output logic [15:0]       stat_conflict,
`endif
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    arb_state_e        state_r;
    logic              rr_ptr_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [DATA_W-1:0] a_rdata_r;
    logic [DATA_W-1:0] b_rdata_r;
    logic              a_rvalid_r;
    logic              b_rvalid_r;

    logic              win_vld_s;
    logic              win_port_s;
    logic              gnt_any_s;
    logic              a_gnt_s;
    logic              b_gnt_s;
    logic              sel_we_s;
    logic              sel_lock_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              other_req_s;
    logic              owner_match_s;
    logic              hold_last_s;

    // Winner selection: owner keeps the port until the hold bound trips, else round-robin.
    always_comb begin
        win_vld_s   = 1'b0;
        win_port_s  = PORT_A;
        hold_last_s = (hold_cnt_r == HOLD_LAST);
        if ((state_r == OWN_A) && a_req && !(hold_last_s && b_req)) begin
            win_vld_s  = 1'b1;
            win_port_s = PORT_A;
        end else if ((state_r == OWN_B) && b_req && !(hold_last_s && a_req)) begin
            win_vld_s  = 1'b1;
            win_port_s = PORT_B;
        end else if (a_req && b_req) begin
            win_vld_s  = 1'b1;
            win_port_s = rr_ptr_r;
        end else if (a_req) begin
            win_vld_s  = 1'b1;
            win_port_s = PORT_A;
        end else if (b_req) begin
            win_vld_s  = 1'b1;
            win_port_s = PORT_B;
        end else begin
            win_vld_s  = 1'b0;
            win_port_s = PORT_A;
        end
    end

    // Winner's request fields; reset forces every grant and memory strobe low at once.
    always_comb begin
        gnt_any_s = win_vld_s & ~reset;
        a_gnt_s   = gnt_any_s & (win_port_s == PORT_A);
        b_gnt_s   = gnt_any_s & (win_port_s == PORT_B);
        if (win_port_s == PORT_A) begin
            sel_we_s      = a_we;
            sel_lock_s    = a_lock;
            sel_addr_s    = a_addr;
            sel_wdata_s   = a_wdata;
            other_req_s   = b_req;
            owner_match_s = (state_r == OWN_A);
        end else begin
            sel_we_s      = b_we;
            sel_lock_s    = b_lock;
            sel_addr_s    = b_addr;
            sel_wdata_s   = b_wdata;
            other_req_s   = a_req;
            owner_match_s = (state_r == OWN_B);
        end
    end

    // Memory-side drive, all zero when nobody is granted.
    always_comb begin
        if (gnt_any_s) begin
            mem_access_addr = sel_addr_s;
            mem_write_data  = sel_wdata_s;
            mem_write_en    = sel_we_s;
            mem_read        = ~sel_we_s;
        end else begin
            mem_access_addr = {ADDR_W{1'b0}};
            mem_write_data  = {DATA_W{1'b0}};
            mem_write_en    = 1'b0;
            mem_read        = 1'b0;
        end
    end

    // Ownership FSM, round-robin pointer, hold counter and per-port read capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            rr_ptr_r   <= PORT_A;
            hold_cnt_r <= {HOLD_W{1'b0}};
            a_rdata_r  <= {DATA_W{1'b0}};
            b_rdata_r  <= {DATA_W{1'b0}};
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
        end else begin
            a_rvalid_r <= a_gnt_s & ~a_we;
            b_rvalid_r <= b_gnt_s & ~b_we;
            if (a_gnt_s && !a_we) begin
                a_rdata_r <= mem_read_data;
            end else begin
                a_rdata_r <= a_rdata_r;
            end
            if (b_gnt_s && !b_we) begin
                b_rdata_r <= mem_read_data;
            end else begin
                b_rdata_r <= b_rdata_r;
            end
            if (win_vld_s) begin
                rr_ptr_r <= ~win_port_s;
                if (sel_lock_s) begin
                    case (win_port_s)
                        PORT_A:  state_r <= OWN_A;
                        PORT_B:  state_r <= OWN_B;
                        default: state_r <= IDLE;
                    endcase
                end else begin
                    state_r <= IDLE;
                end
                // Only a continuing owner facing a waiting peer accumulates hold time.
                if (sel_lock_s && other_req_s && owner_match_s) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_r <= HOLD_LAST;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end else begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
            end else begin
                rr_ptr_r   <= rr_ptr_r;
                state_r    <= IDLE;
                hold_cnt_r <= {HOLD_W{1'b0}};
            end
        end
    end

    assign a_gnt    = a_gnt_s;
    assign b_gnt    = b_gnt_s;
    assign a_rdata  = a_rdata_r;
    assign b_rdata  = b_rdata_r;
    assign a_rvalid = a_rvalid_r;
    assign b_rvalid = b_rvalid_r;

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk           (clk),
        .reset         (reset),
        .stat_clr      (stat_clr),
        .a_gnt         (a_gnt_s),
        .b_gnt         (b_gnt_s),
        .conflict      (a_req & b_req),
        .stat_a_gnt    (stat_a_gnt),
        .stat_b_gnt    (stat_b_gnt),
        .stat_conflict (stat_conflict)
    );
`endif

endmodule
